npu_job_scheduler: RTL
======================

Name: npu_job_scheduler

Overview:
Command-queue scheduler in front of the systolic-array matmul engine. Buffers matmul jobs (A/B/C base addresses, dimension n, tag) in a FIFO and launches them one at a time with a one-cycle new_data pulse. Waits for the array's completion pulse, with a watchdog timeout, then returns an in-order response carrying tag, status and execution cycle count. Sits between the host/DMA command path and the SystolicTemp array.

Parameters:
DEPTH, 4, job FIFO entries; power of 2, at least 2
AW, 12, address width of A/B/C base addresses
N_MAX, 4, largest legal n; jobs with n outside 1..N_MAX are rejected
TW, 4, tag width
CW, 16, cycle-counter width
TIMEOUT, 255, RUN cycles before abort; range 1..2^CW-1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
cmd_valid  in  1  job offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_addr_a  in  AW  base address of matrix A
cmd_addr_b  in  AW  base address of matrix B
cmd_addr_c  in  AW  base address of result C
cmd_n  in  4  matrix dimension
cmd_tag  in  TW  job identifier, returned in the response
arr_new_data  out  1  one-cycle start pulse to the array
arr_addr_a, arr_addr_b, arr_addr_c  out  AW  current job addresses to the array
arr_n  out  4  current job n
arr_done  in  1  one-cycle completion pulse from the array after WRITEBACK
arr_abort  out  1  one-cycle abort pulse on timeout
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_tag  out  TW  tag of the completed job
rsp_status  out  2  00 OK, 01 TIMEOUT, 10 REJECT
rsp_cycles  out  CW  RUN cycles consumed
queue_count  out  $clog2(DEPTH)+1  FIFO occupancy
idle  out  1  FSM in IDLE and FIFO empty

Behaviour:
- Reset: FIFO emptied. All outputs 0 except cmd_ready=1 and idle=1. FSM goes to IDLE.
- FIFO:
  - Push on cmd_valid&&cmd_ready. Pop only in IDLE when non-empty.
  - Push and pop in the same cycle leave the count unchanged.
  - No bypass: an accepted job is poppable one cycle after acceptance, at the earliest.
  - Pointers wrap modulo DEPTH. Jobs issue strictly in acceptance order.
- FSM states: IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - If non-empty, pop the head into job registers.
  - If n==0 or n>N_MAX, go to RESP with status=10, cycles=0, and no array activity.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - arr_new_data=1 for exactly this cycle.
  - Cycle counter cleared.
  - Go to RUN.
  - arr_addr_*/arr_n are driven from the job registers from LAUNCH through RESP, and hold their last value elsewhere.
- RUN: each edge, cnt<=cnt+1.
  - If arr_done=1: go to RESP, status=00, cycles=cnt+1 (done in the first RUN cycle gives cycles=1).
  - Else if cnt+1==TIMEOUT: go to RESP, status=01, cycles=TIMEOUT, and arr_abort=1 during the first RESP cycle only.
  - If done and timeout fall in the same cycle, done wins.
- RESP:
  - rsp_valid=1; tag/status/cycles held stable until rsp_ready=1.
  - On handshake go to IDLE; the next job can be popped in that IDLE cycle.
- arr_done outside RUN is ignored (no state change, no error).
- Latency: job accepted at edge k into an empty, idle scheduler; pop at edge k+1; arr_new_data high between edges k+1 and k+2.
- Reset mid-operation: immediate return to reset values; queued jobs are discarded and no response is issued for them. The array shares rst.

Test Plan:
- Single job: A=16, B=32, C=48, n=4, tag=3 while idle; array pulses done 20 cycles after new_data -> new_data high exactly 1 cycle, one cycle after the acceptance edge. Addresses 16/32/48, n=4 stable. Response tag=3, status=00, cycles=20. idle returns to 1.
- Fill/backpressure: job0 held in RUN (no done); push tags 1..5 -> tags 1..4 accepted, cmd_ready=0, queue_count=4, tag 5 stalls until the first pop. Releasing done per job gives responses in order 0,1,2,3,4,5.
- Timeout: TIMEOUT=50, never assert done -> rsp status=01, cycles=50, arr_abort pulsed exactly 1 cycle. Next queued job launches after the rsp handshake.
- Reject: jobs with n=0 and n=5 -> status=10, cycles=0, arr_new_data never asserted. The following valid n=2 job runs normally.
- Response backpressure and stray done: hold rsp_ready=0 for 10 cycles with 2 jobs queued, inject arr_done pulses -> rsp payload stable, no new_data, queue_count stays 2, the extra done pulses are ignored.
- Reset mid-RUN: with 3 jobs queued, assert rst=0 -> asynchronously all outputs at reset values, queue_count=0. After release, a new job completes with status=00.

Source files
------------

// File: rtl/npu_job_scheduler.sv
// Matmul job scheduler: buffers jobs in a FIFO and runs them one at a time on the
// systolic array, returning in-order responses with status and RUN cycle count.
module npu_job_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 12,
  parameter int unsigned N_MAX   = 4,
  parameter int unsigned TW      = 4,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [AW-1:0]              cmd_addr_a,
  input  logic [AW-1:0]              cmd_addr_b,
  input  logic [AW-1:0]              cmd_addr_c,
  input  logic [3:0]                 cmd_n,
  input  logic [TW-1:0]              cmd_tag,
  output logic                       arr_new_data,
  output logic [AW-1:0]              arr_addr_a,
  output logic [AW-1:0]              arr_addr_b,
  output logic [AW-1:0]              arr_addr_c,
  output logic [3:0]                 arr_n,
  input  logic                       arr_done,
  output logic                       arr_abort,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [TW-1:0]              rsp_tag,
  output logic [1:0]                 rsp_status,
  output logic [CW-1:0]              rsp_cycles,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic                       idle
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned QW = PW + 1;
  localparam int unsigned EW = 3 * AW + 4 + TW;
  localparam logic [3:0]    N_LIMIT = 4'(N_MAX);
  localparam logic [CW-1:0] TO_CNT  = CW'(TIMEOUT);
  localparam logic [QW-1:0] FULL_CNT = QW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    RESP
  } state_t;

  state_t         state;
  logic [EW-1:0]  mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [QW-1:0]  count;
  logic           push;
  logic           pop;
  logic [AW-1:0]  head_a;
  logic [AW-1:0]  head_b;
  logic [AW-1:0]  head_c;
  logic [3:0]     head_n;
  logic [TW-1:0]  head_tag;
  logic [TW-1:0]  job_tag;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_inc;

  assign cmd_ready   = (count != FULL_CNT);
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == IDLE) && (count != '0);
  assign queue_count = count;
  assign idle        = (state == IDLE) && (count == '0);
  assign cnt_inc     = cnt + CW'(1);

  assign {head_a, head_b, head_c, head_n, head_tag} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_addr_a, cmd_addr_b, cmd_addr_c, cmd_n, cmd_tag};
    end
  end

  // Storage is written at the accept edge, so the earliest pop is the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + QW'(1);
        2'b01:   count <= count - QW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      arr_new_data <= 1'b0;
      arr_abort    <= 1'b0;
      arr_addr_a   <= '0;
      arr_addr_b   <= '0;
      arr_addr_c   <= '0;
      arr_n        <= '0;
      job_tag      <= '0;
      cnt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_tag      <= '0;
      rsp_status   <= '0;
      rsp_cycles   <= '0;
    end else begin
      arr_new_data <= 1'b0;
      arr_abort    <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            arr_addr_a <= head_a;
            arr_addr_b <= head_b;
            arr_addr_c <= head_c;
            arr_n      <= head_n;
            job_tag    <= head_tag;
            if (head_n == 4'd0 || head_n > N_LIMIT) begin
              rsp_valid  <= 1'b1;
              rsp_tag    <= head_tag;
              rsp_status <= 2'b10;
              rsp_cycles <= '0;
              state      <= RESP;
            end else begin
              arr_new_data <= 1'b1;
              state        <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt_inc;
          // Completion takes priority over a timeout landing on the same edge.
          if (arr_done) begin
            rsp_valid  <= 1'b1;
            rsp_tag    <= job_tag;
            rsp_status <= 2'b00;
            rsp_cycles <= cnt_inc;
            state      <= RESP;
          end else if (cnt_inc == TO_CNT) begin
            rsp_valid  <= 1'b1;
            rsp_tag    <= job_tag;
            rsp_status <= 2'b01;
            rsp_cycles <= TO_CNT;
            arr_abort  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
